// File: rtl/array_mult_pipe_if.sv
// rtl/array_mult_pipe_if.sv - operand/product stream bundle for array_mult_pipe
interface array_mult_pipe_if #(
   parameter int WIDTH = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 sgn;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 busy;

   modport master (
      output in_valid, a, b, sgn, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, sgn, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/array_mult_pipe.sv
// rtl/array_mult_pipe.sv - fully pipelined WIDTH x WIDTH array multiplier, signed/unsigned per transaction
module array_mult_pipe #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   array_mult_pipe_if.slave    bus
);
   localparam int PW = 2 * WIDTH;

   logic                stall;
   logic                accept;
   logic [WIDTH:0]      vld;
   logic                sg  [0:WIDTH-1];
   logic [PW-1:0]       pp  [0:WIDTH-1][0:WIDTH-1];
   logic [PW-1:0]       sum [1:WIDTH];
   logic [PW-1:0]       ext;
   logic [PW-1:0]       pp_in [0:WIDTH-1];

   assign stall  = vld[WIDTH] && !bus.out_ready;
   assign accept = bus.in_valid && !stall;

   // Rows are sign-extended multiplicand copies; the top row is subtracted later when signed.
   always_comb begin
      ext = bus.sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
      for (int i = 0; i < WIDTH; i++) begin
         pp_in[i] = bus.b[i] ? (ext << i) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         for (int j = 1; j <= WIDTH; j++) begin
            sum[j] <= '0;
         end
      end else if (!stall) begin
         vld    <= {vld[WIDTH-1:0], accept};
         pp[0]  <= pp_in;
         sg[0]  <= bus.sgn;
         sum[1] <= pp[0][0];
         for (int j = 1; j < WIDTH; j++) begin
            pp[j] <= pp[j-1];
            sg[j] <= sg[j-1];
         end
         for (int j = 2; j < WIDTH; j++) begin
            sum[j] <= sum[j-1] + pp[j-1][j-1];
         end
         // The multiplier sign bit carries weight -2^(WIDTH-1) in two's complement.
         sum[WIDTH] <= sg[WIDTH-1] ? sum[WIDTH-1] - pp[WIDTH-1][WIDTH-1]
                                   : sum[WIDTH-1] + pp[WIDTH-1][WIDTH-1];
      end
   end

   assign bus.in_ready  = !stall;
   assign bus.out_valid = vld[WIDTH];
   assign bus.p         = sum[WIDTH];
   assign bus.busy      = |vld;
endmodule
